// File: rtl/stm1_rx_deframer_pkg.sv
// ---------------------------------------------------------------------------
// stm1_rx_deframer_pkg
// Shared constants and types for the STM-1 receive deframer.
//   STM1_Length / STM1_Width : frame geometry (columns per row, rows per frame)
//   A1_BYTE / A2_BYTE        : framing bytes, word is A1 A1 A1 A2 A2 A2
//   SOH_COLS                 : overhead columns stripped at the start of each row
//   framer_state_t           : frame alignment state
// ---------------------------------------------------------------------------
package stm1_rx_deframer_pkg;

    localparam int STM1_Length      = 270;
    localparam int STM1_Width       = 9;
    localparam int STM1_FRAME_BYTES = STM1_Length * STM1_Width;
    localparam int SOH_COLS         = 9;

    localparam logic [7:0] A1_BYTE = 8'hF6;
    localparam logic [7:0] A2_BYTE = 8'h28;

    // Framing word length in bytes; the word occupies row 0, columns 0..FW_BYTES-1.
    localparam int FW_BYTES = 6;
    localparam logic [47:0] FRAME_WORD = {A1_BYTE, A1_BYTE, A1_BYTE,
                                          A2_BYTE, A2_BYTE, A2_BYTE};

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PRESYNC = 2'd1,
        SYNC    = 2'd2
    } framer_state_t;

endpackage

// File: rtl/stm1_rx_deframer_if.sv
// ---------------------------------------------------------------------------
// stm1_rx_deframer_if
// Byte-stream input and VC-4 output bundle of the STM-1 receive deframer.
//   din / din_valid          : received unscrambled byte stream
//   vc4_data/valid/sof       : VC-4 bytes (POH column included)
//   vc4_row / vc4_col        : position of the VC-4 byte (0..8, 0..260)
//   in_sync / lof            : frame alignment status
//   b1_err / b1_err_cnt      : B1 parity error pulse and saturating count
// Modports: slave = deframer, master = byte source / VC-4 sink.
// ---------------------------------------------------------------------------
interface stm1_rx_deframer_if;

    logic [7:0]  din;
    logic        din_valid;
    logic [7:0]  vc4_data;
    logic        vc4_valid;
    logic        vc4_sof;
    logic [3:0]  vc4_row;
    logic [8:0]  vc4_col;
    logic        in_sync;
    logic        lof;
    logic        b1_err;
    logic [15:0] b1_err_cnt;

    modport slave (
        input  din, din_valid,
        output vc4_data, vc4_valid, vc4_sof, vc4_row, vc4_col,
               in_sync, lof, b1_err, b1_err_cnt
    );

    modport master (
        output din, din_valid,
        input  vc4_data, vc4_valid, vc4_sof, vc4_row, vc4_col,
               in_sync, lof, b1_err, b1_err_cnt
    );

endinterface

// File: rtl/stm1_a1a2_detector.sv
// ---------------------------------------------------------------------------
// stm1_a1a2_detector
// Sliding A1A1A1A2A2A2 detector over the valid byte stream.
//   clk, rst_n    : clock, async active-low reset
//   din_i         : received byte
//   din_valid_i   : byte qualifier; the window only shifts on valid bytes
//   match_o       : combinational, high in the cycle of the sixth framing byte
// The window is the five previously accepted bytes plus the byte currently
// presented, so only five bytes need to be stored.
// ---------------------------------------------------------------------------
module stm1_a1a2_detector
    import stm1_rx_deframer_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din_i,
    input  logic       din_valid_i,
    output logic       match_o
);

    logic [39:0] sr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q <= '0;
        end else if (din_valid_i) begin
            sr_q <= {sr_q[31:0], din_i};
        end
    end

    assign match_o = din_valid_i && ({sr_q, din_i} == FRAME_WORD);

endmodule

// File: rtl/stm1_rx_deframer.sv
// ---------------------------------------------------------------------------
// stm1_rx_deframer
// Receive STM-1 deframer: hunts A1/A2 framing, tracks row/column in the
// STM1_LENGTH x STM1_WIDTH frame, strips the overhead columns and emits the
// VC-4 bytes one cycle after they are accepted.
//   clk, rst_n : clock, async active-low reset
//   bus        : stm1_rx_deframer_if.slave (byte input, VC-4 output, status)
// Optional build macro: STM1_B1_CHECK_EN enables the B1 (BIP-8) check;
// without it b1_err and b1_err_cnt are tied to 0.
//
// state   | meaning
// HUNT    | searching every valid byte for the framing word
// PRESYNC | one candidate found, waiting to confirm one frame later
// SYNC    | aligned, emitting VC-4; LOF_FRAMES consecutive misses -> HUNT
// ---------------------------------------------------------------------------
module stm1_rx_deframer
    import stm1_rx_deframer_pkg::*;
#(
    parameter int STM1_LENGTH = STM1_Length,
    parameter int STM1_WIDTH  = STM1_Width,
    parameter int LOF_FRAMES  = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    stm1_rx_deframer_if.slave  bus
);

    localparam int MISS_W = (LOF_FRAMES < 2) ? 1 : $clog2(LOF_FRAMES + 1);

    localparam logic [8:0] LAST_COL    = 9'(STM1_LENGTH - 1);
    localparam logic [3:0] LAST_ROW    = 4'(STM1_WIDTH - 1);
    localparam logic [8:0] FW_LAST_COL = 9'(FW_BYTES - 1);
    localparam logic [8:0] SOH_COL     = 9'(SOH_COLS);
    localparam logic [MISS_W-1:0] MISS_LIMIT = MISS_W'(LOF_FRAMES - 1);

    framer_state_t     state_q;
    logic [8:0]        col_q;
    logic [3:0]        row_q;
    logic [MISS_W-1:0] miss_q;
    logic              in_sync_q;
    logic              lof_q;
    logic              vc4_valid_q;
    logic              vc4_sof_q;
    logic [7:0]        vc4_data_q;
    logic [3:0]        vc4_row_q;
    logic [8:0]        vc4_col_q;

    logic match;
    logic at_last_col;
    logic at_last_row;
    logic at_fw;

    stm1_a1a2_detector u_det (
        .clk         (clk),
        .rst_n       (rst_n),
        .din_i       (bus.din),
        .din_valid_i (bus.din_valid),
        .match_o     (match)
    );

    assign at_last_col = (col_q == LAST_COL);
    assign at_last_row = (row_q == LAST_ROW);
    // Position of the byte that completes the framing word.
    assign at_fw       = (row_q == 4'd0) && (col_q == FW_LAST_COL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HUNT;
            col_q       <= '0;
            row_q       <= '0;
            miss_q      <= '0;
            in_sync_q   <= 1'b0;
            lof_q       <= 1'b1;
            vc4_valid_q <= 1'b0;
            vc4_sof_q   <= 1'b0;
            vc4_data_q  <= '0;
            vc4_row_q   <= '0;
            vc4_col_q   <= '0;
        end else begin
            vc4_valid_q <= 1'b0;
            vc4_sof_q   <= 1'b0;
            if (bus.din_valid) begin
                if (at_last_col) begin
                    col_q <= '0;
                    row_q <= at_last_row ? 4'd0 : row_q + 4'd1;
                end else begin
                    col_q <= col_q + 9'd1;
                end

                if (state_q == SYNC && col_q >= SOH_COL) begin
                    vc4_valid_q <= 1'b1;
                    vc4_sof_q   <= (row_q == 4'd0) && (col_q == SOH_COL);
                    vc4_data_q  <= bus.din;
                    vc4_row_q   <= row_q;
                    vc4_col_q   <= col_q - SOH_COL;
                end

                case (state_q)
                    HUNT: begin
                        if (match) begin
                            // Realign so the next valid byte is row 0, the
                            // column just after the framing word.
                            state_q <= PRESYNC;
                            col_q   <= FW_LAST_COL + 9'd1;
                            row_q   <= 4'd0;
                        end
                    end
                    PRESYNC: begin
                        if (at_fw) begin
                            if (match) begin
                                state_q   <= SYNC;
                                in_sync_q <= 1'b1;
                                lof_q     <= 1'b0;
                                miss_q    <= '0;
                            end else begin
                                state_q <= HUNT;
                            end
                        end
                    end
                    SYNC: begin
                        if (at_fw) begin
                            if (match) begin
                                miss_q <= '0;
                            end else if (miss_q == MISS_LIMIT) begin
                                state_q   <= HUNT;
                                in_sync_q <= 1'b0;
                                lof_q     <= 1'b1;
                                miss_q    <= '0;
                            end else begin
                                miss_q <= miss_q + MISS_W'(1);
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    assign bus.vc4_data  = vc4_data_q;
    assign bus.vc4_valid = vc4_valid_q;
    assign bus.vc4_sof   = vc4_sof_q;
    assign bus.vc4_row   = vc4_row_q;
    assign bus.vc4_col   = vc4_col_q;
    assign bus.in_sync   = in_sync_q;
    assign bus.lof       = lof_q;

`ifdef STM1_B1_CHECK_EN
    logic [7:0]  bip_acc_q;
    logic [7:0]  bip_exp_q;
    logic        acc_full_q;
    logic        exp_ok_q;
    logic        b1_err_q;
    logic [15:0] b1_cnt_q;
    logic        at_b1;
    logic        at_frame_end;

    assign at_b1        = (row_q == 4'd1) && (col_q == 9'd0);
    assign at_frame_end = at_last_row && at_last_col;

    // acc_full_q marks that the running BIP started at a frame boundary;
    // the frame in which SYNC was reached is partial and its B1 is skipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bip_acc_q  <= '0;
            bip_exp_q  <= '0;
            acc_full_q <= 1'b0;
            exp_ok_q   <= 1'b0;
            b1_err_q   <= 1'b0;
            b1_cnt_q   <= '0;
        end else begin
            b1_err_q <= 1'b0;
            if (bus.din_valid) begin
                if (state_q != SYNC) begin
                    bip_acc_q  <= '0;
                    acc_full_q <= 1'b0;
                    exp_ok_q   <= 1'b0;
                end else begin
                    if (at_b1 && exp_ok_q && (bus.din != bip_exp_q)) begin
                        b1_err_q <= 1'b1;
                        if (b1_cnt_q != 16'hFFFF) begin
                            b1_cnt_q <= b1_cnt_q + 16'd1;
                        end
                    end
                    if (at_frame_end) begin
                        bip_exp_q  <= bip_acc_q ^ bus.din;
                        exp_ok_q   <= acc_full_q;
                        bip_acc_q  <= '0;
                        acc_full_q <= 1'b1;
                    end else begin
                        bip_acc_q <= bip_acc_q ^ bus.din;
                    end
                end
            end
        end
    end

    assign bus.b1_err     = b1_err_q;
    assign bus.b1_err_cnt = b1_cnt_q;
`else
    assign bus.b1_err     = 1'b0;
    assign bus.b1_err_cnt = '0;
`endif

endmodule
